serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the arithmetic slice of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts two WIDTH-bit operands plus carry-in, adds one bit per cycle
// LSB-first through a single full adder, and presents {cout, sum} with a valid/ready handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             fa_sum, fa_cout;

    full_adder u_full_adder (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + 1'b1;
                // Result registers only change on the final bit so the previous answer persists.
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    sum_d   = {fa_sum, res_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv8, ir8, ov8, or8, ci8, co8;
    logic [7:0]  a8, b8, s8;
    logic        iv16, ir16, ov16, or16, ci16, co16;
    logic [15:0] a16, b16, s16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .a         (a8),
        .b         (b8),
        .cin       (ci8),
        .out_valid (ov8),
        .out_ready (or8),
        .sum       (s8),
        .cout      (co8)
    );

    serial_adder #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .a         (a16),
        .b         (b16),
        .cin       (ci16),
        .out_valid (ov16),
        .out_ready (or16),
        .sum       (s16),
        .cout      (co16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic v);
        if (w == 8) begin
            a8 = a[7:0]; b8 = b[7:0]; ci8 = c; iv8 = v;
        end else begin
            a16 = a[15:0]; b16 = b[15:0]; ci16 = c; iv16 = v;
        end
    endtask

    task automatic set_ready(input int w, input logic r);
        if (w == 8) or8 = r;
        else or16 = r;
    endtask

    task automatic get(input int w, output logic ov, output logic ir, output logic co,
                       output logic [31:0] s);
        if (w == 8) begin
            ov = ov8; ir = ir8; co = co8; s = 32'(s8);
        end else begin
            ov = ov16; ir = ir16; co = co16; s = 32'(s16);
        end
    endtask

    // One full transaction: accept, noisy inputs during RUN, hold for `hold` cycles, drain.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input int hold);
        logic [32:0] mask, total;
        logic [31:0] exp_s, s;
        logic        exp_c, ov, ir, co;
        int          lat;
        mask  = (33'd1 << w) - 33'd1;
        total = (33'(a) & mask) + (33'(b) & mask) + 33'(c);
        exp_s = 32'(total & mask);
        exp_c = total[w];
        drive(w, a, b, c, 1'b1);
        @(posedge clk); #1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k <= w) drive(w, $urandom, $urandom, 1'($urandom), 1'($urandom));
            else drive(w, 32'd0, 32'd0, 1'b0, 1'b0);
            @(posedge clk); #1;
            get(w, ov, ir, co, s);
            if (k == 1) check("busy_in_ready", 64'(ir), 64'd0);
            if (ov) begin
                lat = k;
                break;
            end
        end
        drive(w, 32'd0, 32'd0, 1'b0, 1'b0);
        check("latency", 64'(lat), 64'(w));
        check("sum", 64'(s), 64'(exp_s));
        check("cout", 64'(co), 64'(exp_c));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            get(w, ov, ir, co, s);
            check("hold_valid", 64'(ov), 64'd1);
            check("hold_in_ready", 64'(ir), 64'd0);
            check("hold_sum", 64'(s), 64'(exp_s));
            check("hold_cout", 64'(co), 64'(exp_c));
        end
        set_ready(w, 1'b1);
        @(posedge clk); #1;
        set_ready(w, 1'b0);
        get(w, ov, ir, co, s);
        check("drain_in_ready", 64'(ir), 64'd1);
        check("drain_valid", 64'(ov), 64'd0);
        check("retain_sum", 64'(s), 64'(exp_s));
        check("retain_cout", 64'(co), 64'(exp_c));
    endtask

    initial begin
        rst = 1'b1;
        drive(8, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(16, 32'd0, 32'd0, 1'b0, 1'b0);
        or8 = 1'b0;
        or16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready8", 64'(ir8), 64'd1);
        check("rst_valid8", 64'(ov8), 64'd0);
        check("rst_sum8", 64'(s8), 64'd0);
        check("rst_cout8", 64'(co8), 64'd0);
        check("rst_in_ready16", 64'(ir16), 64'd1);
        check("rst_valid16", 64'(ov16), 64'd0);

        run_op(8, 32'h5A, 32'hA5, 1'b0, 0);
        run_op(8, 32'hFF, 32'h01, 1'b0, 0);
        run_op(8, 32'hFF, 32'hFF, 1'b1, 5);

        // Reset mid-operation while bit 3 is being processed.
        drive(8, 32'h77, 32'h99, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(8, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        or8 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        or8 = 1'b0;
        check("midrst_in_ready", 64'(ir8), 64'd1);
        check("midrst_valid", 64'(ov8), 64'd0);
        check("midrst_sum", 64'(s8), 64'd0);
        check("midrst_cout", 64'(co8), 64'd0);
        repeat (12) begin
            @(posedge clk); #1;
            check("midrst_no_pulse", 64'(ov8), 64'd0);
        end
        run_op(8, 32'h03, 32'h04, 1'b0, 0);

        for (int i = 0; i < 1000; i++) begin
            run_op(8, $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 1000; i++) begin
            run_op(16, $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
